trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Machine-mode trap/return sequencer for the single-issue RV32 core.
- Takes per-instruction exception, MRET and WFI flags from the control decoder, plus the machine interrupt lines.
- Arbitrates between synchronous exceptions and interrupts, then drives the shared CSR write port through a fixed multi-cycle write sequence (mepc, mcause, mstatus).
- Redirects the PC to the trap vector or mepc; stalls the pipeline while sequencing.

Parameters:
- XLEN, 32, datapath/CSR width.
- VECTORED_EN, 1, 1 = honour mtvec.MODE=1 for interrupts; 0 = always direct mode.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  an instruction is at the retire point this cycle
- instr_pc  in  XLEN  PC of that instruction
- exc_request  in  1  ECALL/EBREAK decoded
- inst_invalid  in  1  illegal instruction decoded
- exc_cause_in  in  XLEN  cause code supplied with exc_request
- exc_ret  in  1  MRET decoded
- is_wfi  in  1  WFI decoded
- irq_msip, irq_mtip, irq_meip  in  1 each  machine software, timer and external interrupt pending
- mstatus_in  in  XLEN  current mstatus
- mie_in  in  XLEN  current mie
- mtvec_in  in  XLEN  current mtvec
- mepc_in  in  XLEN  current mepc
- kill  out  1  suppress the retiring instruction's side effects (combinational)
- stall  out  1  hold fetch/retire
- csr_we  out  1  CSR write strobe
- csr_addr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- pc_redirect  out  1  one-cycle redirect strobe
- pc_target  out  XLEN  redirect target
- trap_taken  out  1  pulse coincident with trap redirect
- wfi_sleep  out  1  core is waiting in WFI

Behaviour:
- Reset: state=IDLE. All registered outputs 0: stall, csr_we, csr_addr, csr_wdata, pc_redirect, pc_target, trap_taken, wfi_sleep. Latched epc/cause cleared.
- Reset asserted mid-sequence: state returns to IDLE next edge; no further CSR writes or redirect are issued.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT, WFI.
- Pending interrupt vector: pend = {meip&mie[11], msip&mie[3], mtip&mie[7]}.
- Interrupt enable: irq_en = mstatus_in[3] & |pend.
- IDLE event priority, evaluated only when instr_valid=1, highest first:
  - inst_invalid: cause=2.
  - exc_request: cause=exc_cause_in.
  - irq_en: cause = 0x8000000B (MEI) > 0x80000003 (MSI) > 0x80000007 (MTI).
  - exc_ret.
  - is_wfi.
- Trap event (the first three): kill=1 in the same cycle. Latch epc=instr_pc and cause, then go SAVE_EPC.
  - For interrupts, the instruction at instr_pc is killed and is re-executed after return.
- exc_ret: kill=0 (MRET itself has no writeback); go MRET_STATUS.
- is_wfi: go WFI.
- stall=1 in every state except IDLE. It is registered and asserted from the cycle after the event.
- SAVE_EPC: csr_we=1, addr 0x341, wdata={epc[XLEN-1:2],2'b00}.
- SAVE_CAUSE: csr_we=1, addr 0x342, wdata=cause.
- SAVE_STATUS: csr_we=1, addr 0x300. wdata=mstatus_in with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
- Trap target:
  - base = {mtvec_in[XLEN-1:2],2'b00}.
  - If VECTORED_EN, mtvec_in[1:0]==1 and cause[31]=1: target = base + 4*cause[4:0].
  - Otherwise target = base.
- MRET_STATUS: csr_we=1, addr 0x300. wdata=mstatus_in with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11. Target = mepc_in.
- REDIRECT: pc_redirect=1 and pc_target=target for exactly one cycle. trap_taken=1 only for trap paths. Next state IDLE, with stall deasserted the cycle after.
- Trap latency: event cycle → 3 CSR write cycles → redirect on cycle 4.
- MRET latency: event cycle → 1 CSR write cycle → redirect on cycle 2.
- WFI: wfi_sleep=1, stall=1. Exit when |pend=1, regardless of mstatus.MIE. Exit returns to IDLE with wfi_sleep=0.
  - If the interrupt is enabled, it is taken on the next valid instruction per IDLE rules.
- Events arriving in non-IDLE states are ignored. The pipeline is stalled, so the decoder holds its inputs.
- csr_we is never asserted in IDLE, WFI or REDIRECT.

Test Plan:
- ECALL at pc 0x100, exc_cause_in=11, mtvec=0x200, mstatus=0x8 → writes, one per cycle: (0x341,0x100), (0x342,0xB), (0x300,0x1880). Then pc_redirect to 0x200 with trap_taken=1 on cycle 4.
- inst_invalid and exc_request both set at pc 0x40 → mcause write 0x2. Single trap only.
- irq_mtip=1, mie=0x80, mstatus=0x8, mtvec=0x201, instr_pc=0x300 → kill=1, mepc=0x300, mcause=0x80000007, target 0x21C.
- irq_meip and irq_mtip together, both enabled, with exc_request (cause 11) → cause 11 wins. With no exception, cause 0x8000000B is selected.
- MRET with mstatus=0x1880, mepc=0x104 → write (0x300,0x1888), redirect 0x104 on cycle 2, trap_taken=0.
- WFI with mstatus=0; mie=0x80; mtip rises after 5 cycles → wfi_sleep and stall stay high 5 cycles, then drop; no CSR writes, no redirect.
- rst pulsed during SAVE_CAUSE → no further csr_we, no pc_redirect, all outputs 0, state IDLE.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer.
// Chooses between synchronous exceptions, interrupts, MRET and WFI at the retire point.
// Walks the shared CSR write port through the mepc/mcause/mstatus updates, then redirects the PC.
// All outputs except kill are registered from the next state, so they line up with the state they belong to.
module trap_sequencer #(
   parameter int XLEN        = 32,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr_pc,
   input  logic            exc_request,
   input  logic            inst_invalid,
   input  logic [XLEN-1:0] exc_cause_in,
   input  logic            exc_ret,
   input  logic            is_wfi,
   input  logic            irq_msip,
   input  logic            irq_mtip,
   input  logic            irq_meip,
   input  logic [XLEN-1:0] mstatus_in,
   input  logic [XLEN-1:0] mie_in,
   input  logic [XLEN-1:0] mtvec_in,
   input  logic [XLEN-1:0] mepc_in,
   output logic            kill,
   output logic            stall,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            pc_redirect,
   output logic [XLEN-1:0] pc_target,
   output logic            trap_taken,
   output logic            wfi_sleep
);

   typedef enum logic [2:0] {
      IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT, WFI
   } state_t;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   state_t          state, state_next;
   logic [XLEN-1:0] epc, epc_next;
   logic [XLEN-1:0] cause, cause_next;
   logic            is_trap, is_trap_next;

   logic [2:0]      pend;
   logic            irq_en;
   logic            trap_event;
   logic [XLEN-1:0] irq_cause;
   logic [XLEN-1:0] trap_base;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] status_trap;
   logic [XLEN-1:0] status_mret;

   logic            stall_next, csr_we_next, pc_redirect_next, trap_taken_next, wfi_sleep_next;
   logic [11:0]     csr_addr_next;
   logic [XLEN-1:0] csr_wdata_next, pc_target_next;
   logic            unused_bits;

   // Only the MSIE/MTIE/MEIE bits of mie matter here; fold the rest away.
   assign unused_bits = ^mie_in;

   assign pend       = {irq_meip & mie_in[11], irq_msip & mie_in[3], irq_mtip & mie_in[7]};
   assign irq_en     = mstatus_in[3] & (|pend);
   assign trap_event = inst_invalid | exc_request | irq_en;

   // The retiring instruction is squashed for any trap, including interrupts (it re-executes after return).
   assign kill = (state == IDLE) & instr_valid & trap_event;

   // Interrupt cause: external beats software beats timer.
   always_comb begin
      irq_cause         = '0;
      irq_cause[XLEN-1] = 1'b1;
      if (pend[2])      irq_cause[3:0] = 4'hB;
      else if (pend[1]) irq_cause[3:0] = 4'h3;
      else              irq_cause[3:0] = 4'h7;
   end

   // Trap vector: direct base, or base + 4*code for interrupts in vectored mode.
   always_comb begin
      trap_base   = {mtvec_in[XLEN-1:2], 2'b00};
      trap_target = trap_base;
      if (VECTORED_EN && (mtvec_in[1:0] == 2'b01) && cause[XLEN-1])
         trap_target = trap_base + {{(XLEN-7){1'b0}}, cause[4:0], 2'b00};
   end

   // mstatus images for trap entry (stack MIE into MPIE) and MRET (pop MPIE into MIE).
   always_comb begin
      status_trap        = mstatus_in;
      status_trap[7]     = mstatus_in[3];
      status_trap[3]     = 1'b0;
      status_trap[12:11] = 2'b11;
      status_mret        = mstatus_in;
      status_mret[3]     = mstatus_in[7];
      status_mret[7]     = 1'b1;
      status_mret[12:11] = 2'b11;
   end

   // Next state and trap context capture; events are only looked at in IDLE.
   always_comb begin
      state_next   = state;
      epc_next     = epc;
      cause_next   = cause;
      is_trap_next = is_trap;
      case (state)
         IDLE: begin
            if (instr_valid) begin
               if (trap_event) begin
                  state_next   = SAVE_EPC;
                  epc_next     = instr_pc;
                  is_trap_next = 1'b1;
                  if (inst_invalid)     cause_next = {{(XLEN-2){1'b0}}, 2'b10};
                  else if (exc_request) cause_next = exc_cause_in;
                  else                  cause_next = irq_cause;
               end else if (exc_ret) begin
                  state_next   = MRET_STATUS;
                  is_trap_next = 1'b0;
               end else if (is_wfi) begin
                  state_next = WFI;
               end
            end
         end
         SAVE_EPC:    state_next = SAVE_CAUSE;
         SAVE_CAUSE:  state_next = SAVE_STATUS;
         SAVE_STATUS: state_next = REDIRECT;
         MRET_STATUS: state_next = REDIRECT;
         REDIRECT:    state_next = IDLE;
         WFI:         if (|pend) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   // Output values for the state being entered, so each registered output matches its state.
   always_comb begin
      stall_next       = (state_next != IDLE);
      csr_we_next      = 1'b0;
      csr_addr_next    = '0;
      csr_wdata_next   = '0;
      pc_redirect_next = 1'b0;
      pc_target_next   = '0;
      trap_taken_next  = 1'b0;
      wfi_sleep_next   = 1'b0;
      case (state_next)
         SAVE_EPC: begin
            csr_we_next    = 1'b1;
            csr_addr_next  = ADDR_MEPC;
            csr_wdata_next = {epc_next[XLEN-1:2], 2'b00};
         end
         SAVE_CAUSE: begin
            csr_we_next    = 1'b1;
            csr_addr_next  = ADDR_MCAUSE;
            csr_wdata_next = cause_next;
         end
         SAVE_STATUS: begin
            csr_we_next    = 1'b1;
            csr_addr_next  = ADDR_MSTATUS;
            csr_wdata_next = status_trap;
         end
         MRET_STATUS: begin
            csr_we_next    = 1'b1;
            csr_addr_next  = ADDR_MSTATUS;
            csr_wdata_next = status_mret;
         end
         REDIRECT: begin
            pc_redirect_next = 1'b1;
            pc_target_next   = is_trap_next ? trap_target : mepc_in;
            trap_taken_next  = is_trap_next;
         end
         WFI:     wfi_sleep_next = 1'b1;
         default: ;
      endcase
   end

   // State, trap context and output registers; reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         epc         <= '0;
         cause       <= '0;
         is_trap     <= 1'b0;
         stall       <= 1'b0;
         csr_we      <= 1'b0;
         csr_addr    <= '0;
         csr_wdata   <= '0;
         pc_redirect <= 1'b0;
         pc_target   <= '0;
         trap_taken  <= 1'b0;
         wfi_sleep   <= 1'b0;
      end else begin
         state       <= state_next;
         epc         <= epc_next;
         cause       <= cause_next;
         is_trap     <= is_trap_next;
         stall       <= stall_next;
         csr_we      <= csr_we_next;
         csr_addr    <= csr_addr_next;
         csr_wdata   <= csr_wdata_next;
         pc_redirect <= pc_redirect_next;
         pc_target   <= pc_target_next;
         trap_taken  <= trap_taken_next;
         wfi_sleep   <= wfi_sleep_next;
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus randomized events against a behavioural model.
// Expected CSR writes and redirects go into a scoreboard queue; a negedge monitor pops and compares.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, exc_request, inst_invalid, exc_ret, is_wfi;
   logic        irq_msip, irq_mtip, irq_meip;
   logic [31:0] instr_pc, exc_cause_in, mstatus_in, mie_in, mtvec_in, mepc_in;
   logic        kill, stall, csr_we, pc_redirect, trap_taken, wfi_sleep;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, pc_target;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit          redir;
      logic [11:0] addr;
      logic [31:0] data;
      bit          trap;
      int          at;
   } exp_t;
   exp_t sb[$];

   trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .exc_request(exc_request), .inst_invalid(inst_invalid), .exc_cause_in(exc_cause_in),
      .exc_ret(exc_ret), .is_wfi(is_wfi), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
      .irq_meip(irq_meip), .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in),
      .mepc_in(mepc_in), .kill(kill), .stall(stall), .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
      .trap_taken(trap_taken), .wfi_sleep(wfi_sleep)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every CSR write or redirect must match the next scoreboard entry, on its expected cycle.
   always @(negedge clk) begin
      exp_t e;
      if (csr_we || pc_redirect) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output at cycle %0d: we=%0b addr=%h data=%h redir=%0b tgt=%h, want none",
                     cyc, csr_we, csr_addr, csr_wdata, pc_redirect, pc_target);
         end else begin
            e = sb.pop_front();
            if (e.redir) begin
               if (!(pc_redirect && !csr_we && pc_target == e.data && trap_taken == e.trap && cyc == e.at)) begin
                  bad++;
                  $display("FAIL redirect: got redir=%0b we=%0b tgt=%h trap=%0b cyc=%0d, want tgt=%h trap=%0b cyc=%0d",
                           pc_redirect, csr_we, pc_target, trap_taken, cyc, e.data, e.trap, e.at);
               end else
                  $display("redirect ok: tgt=%h trap=%0b cyc=%0d", pc_target, trap_taken, cyc);
            end else begin
               if (!(csr_we && !pc_redirect && csr_addr == e.addr && csr_wdata == e.data && cyc == e.at)) begin
                  bad++;
                  $display("FAIL csr_write: got we=%0b addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                           csr_we, csr_addr, csr_wdata, cyc, e.addr, e.data, e.at);
               end else
                  $display("csr write ok: addr=%h data=%h cyc=%0d", csr_addr, csr_wdata, cyc);
            end
         end
      end
      if (trap_taken && !pc_redirect) begin
         total++;
         bad++;
         $display("FAIL trap_taken_alone at cycle %0d: got 1, want 0", cyc);
      end
   end

   // Reference model: event class (0 none, 1 trap, 2 mret, 3 wfi) and cause from the current inputs.
   task automatic classify(output int kind, output logic [31:0] cause);
      bit mei, msi, mti;
      mei = irq_meip && mie_in[11];
      msi = irq_msip && mie_in[3];
      mti = irq_mtip && mie_in[7];
      kind  = 0;
      cause = 0;
      if (!instr_valid) kind = 0;
      else if (inst_invalid) begin kind = 1; cause = 2; end
      else if (exc_request)  begin kind = 1; cause = exc_cause_in; end
      else if (mstatus_in[3] && (mei || msi || mti)) begin
         kind  = 1;
         cause = mei ? 32'h8000000B : (msi ? 32'h80000003 : 32'h80000007);
      end
      else if (exc_ret) kind = 2;
      else if (is_wfi)  kind = 3;
   endtask

   function automatic logic [31:0] trap_status(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
   endfunction

   function automatic logic [31:0] mret_status(input logic [31:0] m);
      return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
   endfunction

   function automatic logic [31:0] target_of(input logic [31:0] mtvec, input logic [31:0] cause);
      logic [31:0] base;
      base = mtvec & ~32'h3;
      if ((mtvec % 4) == 1 && cause >= 32'h8000_0000) return base + 4 * (cause % 32);
      return base;
   endfunction

   function automatic exp_t mk(input bit redir, input logic [11:0] a, input logic [31:0] d,
                               input bit trap, input int at);
      exp_t e;
      e.redir = redir; e.addr = a; e.data = d; e.trap = trap; e.at = at;
      return e;
   endfunction

   task automatic setin(input logic v, input logic [31:0] pc, input logic inv, input logic exc,
                        input logic [31:0] ec, input logic ret, input logic wfi,
                        input logic msip, input logic mtip, input logic meip,
                        input logic [31:0] ms, input logic [31:0] mie, input logic [31:0] mtvec,
                        input logic [31:0] mepc);
      instr_valid = v; instr_pc = pc; inst_invalid = inv; exc_request = exc; exc_cause_in = ec;
      exc_ret = ret; is_wfi = wfi; irq_msip = msip; irq_mtip = mtip; irq_meip = meip;
      mstatus_in = ms; mie_in = mie; mtvec_in = mtvec; mepc_in = mepc;
   endtask

   task automatic clear_event();
      instr_valid = 0; inst_invalid = 0; exc_request = 0; exc_ret = 0; is_wfi = 0;
   endtask

   // Called just after a posedge with inputs set: predicts, then walks the sequence checking kill/stall.
   task automatic do_event();
      int kind, e, lat;
      logic [31:0] cause;
      classify(kind, cause);
      e   = cyc;
      lat = 0;
      if (kind == 1) begin
         sb.push_back(mk(0, 12'h341, instr_pc & ~32'h3, 0, e + 1));
         sb.push_back(mk(0, 12'h342, cause, 0, e + 2));
         sb.push_back(mk(0, 12'h300, trap_status(mstatus_in), 0, e + 3));
         sb.push_back(mk(1, 12'h000, target_of(mtvec_in, cause), 1, e + 4));
         lat = 4;
      end else if (kind == 2) begin
         sb.push_back(mk(0, 12'h300, mret_status(mstatus_in), 0, e + 1));
         sb.push_back(mk(1, 12'h000, mepc_in, 0, e + 2));
         lat = 2;
      end
      $display("event cyc=%0d kind=%0d cause=%h pc=%h", e, kind, cause, instr_pc);
      @(negedge clk);
      chk("kill", {31'b0, kill}, {31'b0, kind == 1});
      chk("stall_event", {31'b0, stall}, 32'd0);
      for (int k = 1; k <= lat + 1; k++) begin
         @(posedge clk); #1;
         if (k == lat || lat == 0) clear_event();
         @(negedge clk);
         chk("stall_seq", {31'b0, stall}, {31'b0, k <= lat});
      end
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, {31'b0, stall}, 0);
      chk({tag, "_csr_we"}, {31'b0, csr_we}, 0);
      chk({tag, "_csr_addr"}, {20'b0, csr_addr}, 0);
      chk({tag, "_csr_wdata"}, csr_wdata, 0);
      chk({tag, "_pc_redirect"}, {31'b0, pc_redirect}, 0);
      chk({tag, "_pc_target"}, pc_target, 0);
      chk({tag, "_trap_taken"}, {31'b0, trap_taken}, 0);
      chk({tag, "_wfi_sleep"}, {31'b0, wfi_sleep}, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      logic [31:0] r;
      rst = 1;
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // ECALL
      setin(1, 32'h100, 0, 1, 11, 0, 0, 0, 0, 0, 32'h8, 32'h0, 32'h200, 32'h0);
      do_event();
      // Illegal instruction wins over ECALL
      @(posedge clk); #1;
      setin(1, 32'h40, 1, 1, 11, 0, 0, 0, 0, 0, 32'h8, 32'h0, 32'h200, 32'h0);
      do_event();
      // Timer interrupt, vectored mtvec
      @(posedge clk); #1;
      setin(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h80, 32'h201, 32'h0);
      do_event();
      // Exception beats enabled interrupts
      @(posedge clk); #1;
      setin(1, 32'h400, 0, 1, 11, 0, 0, 0, 1, 1, 32'h8, 32'h880, 32'h201, 32'h0);
      do_event();
      // External beats timer
      @(posedge clk); #1;
      setin(1, 32'h404, 0, 0, 0, 0, 0, 0, 1, 1, 32'h8, 32'h880, 32'h201, 32'h0);
      do_event();
      // MRET
      @(posedge clk); #1;
      setin(1, 32'h500, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1880, 32'h0, 32'h200, 32'h104);
      do_event();

      // WFI with interrupts globally disabled; timer rises after 5 sleeping cycles
      @(posedge clk); #1;
      setin(1, 32'h600, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h80, 32'h200, 32'h0);
      $display("event cyc=%0d kind=3 (wfi)", cyc);
      @(negedge clk);
      chk("wfi_kill", {31'b0, kill}, 0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 5) begin irq_mtip = 1; clear_event(); end
         @(negedge clk);
         chk("wfi_sleep", {31'b0, wfi_sleep}, {31'b0, k <= 5});
         chk("wfi_stall", {31'b0, stall}, {31'b0, k <= 5});
      end
      irq_mtip = 0;

      // Reset during SAVE_CAUSE: only the first two writes appear, then everything is quiet
      @(posedge clk); #1;
      setin(1, 32'h700, 0, 1, 11, 0, 0, 0, 0, 0, 32'h8, 32'h0, 32'h200, 32'h0);
      e = cyc;
      sb.push_back(mk(0, 12'h341, 32'h700, 0, e + 1));
      sb.push_back(mk(0, 12'h342, 32'hB, 0, e + 2));
      $display("event cyc=%0d reset mid-sequence", e);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      clear_event();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0 || k == 4) chk_all_zero("midreset");
         @(posedge clk); #1;
      end
      chk("midreset_sb", sb.size(), 0);

      // Randomized events
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         r = $urandom;
         setin(($urandom % 8) != 0, $urandom, ($urandom % 5) == 0, ($urandom % 4) == 0,
               $urandom % 16, ($urandom % 3) == 0, 1'b0,
               ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
               $urandom, r | ($urandom & 32'h888), $urandom, $urandom);
         do_event();
         @(posedge clk); #1;
         irq_msip = 0; irq_mtip = 0; irq_meip = 0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("final_sb", sb.size(), 0);
      chk("final_stall", {31'b0, stall}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
